// File: rtl/wb_load_stage_if.sv
// -----------------------------------------------------------------------------
// wb_load_stage_if
//
// Purpose:
//   MEM-stage to write-back-stage instruction bus. One instruction moves on
//   each cycle where in_valid and in_ready are both high.
//
// Modports:
//   master : MEM stage. Drives the instruction fields and in_valid, and
//            samples in_ready.
//   slave  : write-back stage. Samples the instruction fields and drives
//            in_ready.
//
// Signals:
//   in_valid            MEM stage presents an instruction
//   in_ready            write-back stage can accept
//   mem_read_flag       instruction is a load
//   mem_write_flag      instruction is a store
//   mem_sign_ext_flag   sign-extend the load result
//   mem_sel[SEL_W]      byte-lane mask; its popcount is the access size
//   result_in           ALU result; effective address for loads
//   reg_write_en_in     instruction writes a register
//   reg_write_addr_in   destination register
//   current_pc_addr_in  instruction PC
// -----------------------------------------------------------------------------
interface wb_load_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) ();

  localparam int SEL_W = DATA_WIDTH / 8;

  logic                      in_valid;
  logic                      in_ready;
  logic                      mem_read_flag;
  logic                      mem_write_flag;
  logic                      mem_sign_ext_flag;
  logic [SEL_W-1:0]          mem_sel;
  logic [DATA_WIDTH-1:0]     result_in;
  logic                      reg_write_en_in;
  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in;
  logic [ADDR_WIDTH-1:0]     current_pc_addr_in;

  modport master (
    output in_valid,
    output mem_read_flag,
    output mem_write_flag,
    output mem_sign_ext_flag,
    output mem_sel,
    output result_in,
    output reg_write_en_in,
    output reg_write_addr_in,
    output current_pc_addr_in,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  mem_read_flag,
    input  mem_write_flag,
    input  mem_sign_ext_flag,
    input  mem_sel,
    input  result_in,
    input  reg_write_en_in,
    input  reg_write_addr_in,
    input  current_pc_addr_in,
    output in_ready
  );

endinterface : wb_load_stage_if

// File: rtl/wb_load_stage.sv
// -----------------------------------------------------------------------------
// wb_load_stage
//
// Purpose:
//   Registered write-back stage of the TinyMIPS core. It accepts one retiring
//   instruction per handshake from the MEM stage. Non-loads retire on the next
//   edge. A load waits in WAIT_RAM, with in_ready low, until the RAM returns
//   data. The stage then extracts the byte, half, word or (64-bit builds)
//   double-word field, sign- or zero-extends it, and retires it.
//
// Parameters:
//   DATA_WIDTH      datapath width, 32 or 64
//   ADDR_WIDTH      address / PC width
//   REG_ADDR_WIDTH  register-file address width
//
// Ports:
//   clk                 clock; all state changes on the rising edge
//   rst                 synchronous, active-high reset
//   mem_if (slave)      MEM-stage handshake and instruction fields
//   ram_read_data       RAM read data
//   ram_data_valid      read data valid this cycle; used only in WAIT_RAM
//   result_out          write-back data, held between retires
//   reg_write_en_out    one-cycle register write pulse per retire
//   reg_write_addr_out  write-back register, held between retires
//   debug_reg_write_en  copy of reg_write_en_out for the trace port
//   debug_pc_addr_out   PC of the last retired instruction
//   load_misalign       one-cycle pulse when a load is rejected
//
// Build option:
//   WB_MISALIGN_TRAP_EN  When defined, an illegal load (bad lane mask or
//                        misaligned address) retires on the next edge with no
//                        register write, and load_misalign pulses. When
//                        undefined, load_misalign is tied 0. The address is
//                        then truncated to the access size, and an illegal
//                        lane mask is treated as a full-width load.
// -----------------------------------------------------------------------------
module wb_load_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  wb_load_stage_if.slave            mem_if,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  input  logic                      ram_data_valid,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      reg_write_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
  output logic                      debug_reg_write_en,
  output logic [ADDR_WIDTH-1:0]     debug_pc_addr_out,
  output logic                      load_misalign
);

  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(SEL_W);
  // log2 of the access size for a full-width load
  localparam logic [1:0] FULL_LOG = 2'(LANE_W);

  typedef enum logic {
    IDLE,
    WAIT_RAM
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q,    state_d;
  logic [DATA_WIDTH-1:0]     result_q,   result_d;
  logic                      wr_en_q,    wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [ADDR_WIDTH-1:0]     pc_q,       pc_d;

  // Context of the load waiting in WAIT_RAM
  logic                      ld_sign_q,  ld_sign_d;
  logic [LANE_W-1:0]         ld_lane_q,  ld_lane_d;
  logic [1:0]                ld_size_q,  ld_size_d;  // log2(bytes)
  logic                      ld_wr_en_q, ld_wr_en_d;
  logic [REG_ADDR_WIDTH-1:0] ld_addr_q,  ld_addr_d;
  logic [ADDR_WIDTH-1:0]     ld_pc_q,    ld_pc_d;

`ifdef WB_MISALIGN_TRAP_EN
  logic                      misalign_q, misalign_d;
`endif

  // ---------------------------------------------------------------------------
  // Load decode: access size from popcount, lane from low address bits
  // ---------------------------------------------------------------------------
  logic [3:0]        sel_pop;
  logic [1:0]        size_log;
  logic [LANE_W-1:0] size_mask;   // low lane bits that must be zero
  logic [LANE_W-1:0] lane_raw;
  logic [LANE_W-1:0] lane_eff;

  always_comb begin
    // NOTE: every signal written here gets a default value first. Otherwise a
    // path that skips an assignment would infer a latch.
    sel_pop  = '0;
    size_log = FULL_LOG;
    for (int i = 0; i < SEL_W; i++) begin
      sel_pop = sel_pop + 4'(mem_if.mem_sel[i]);
    end

    // Any other popcount keeps the full-width default.
    case (sel_pop)
      4'd1:    size_log = 2'd0;
      4'd2:    size_log = 2'd1;
      4'd4:    size_log = 2'd2;
      4'd8:    size_log = 2'd3;  // reachable only when SEL_W == 8
      default: size_log = FULL_LOG;
    endcase

    case (size_log)
      2'd0:    size_mask = '0;
      2'd1:    size_mask = LANE_W'(1);
      2'd2:    size_mask = LANE_W'(3);
      default: size_mask = LANE_W'(7);
    endcase

    lane_raw = mem_if.result_in[LANE_W-1:0];
    // For a legal load this changes nothing. Otherwise the address is
    // truncated down to the access size.
    lane_eff = lane_raw & ~size_mask;
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic size_ok;
  logic load_illegal;

  assign size_ok      = (sel_pop == 4'd1) || (sel_pop == 4'd2) ||
                        (sel_pop == 4'd4) || ((sel_pop == 4'd8) && (SEL_W == 8));
  assign load_illegal = !size_ok || (|(lane_raw & size_mask));
`endif

  // ---------------------------------------------------------------------------
  // Field extraction and extension of the returning RAM word
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shifted;
  logic [6:0]            field_bits;
  logic [DATA_WIDTH-1:0] field_mask;
  logic [DATA_WIDTH-1:0] field_top;
  logic                  field_msb;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    shifted    = ram_read_data >> {ld_lane_q, 3'b000};
    field_bits = 7'd8 << ld_size_q;
    // For a full-width field the shift gives zero, so the mask wraps to all
    // ones and the data passes through unchanged.
    field_mask = (DATA_WIDTH'(1) << field_bits) - DATA_WIDTH'(1);
    field_top  = field_mask ^ (field_mask >> 1);
    field_msb  = |(shifted & field_top);
    load_data  = (shifted & field_mask) |
                 ((ld_sign_q && field_msb) ? ~field_mask : '0);
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign mem_if.in_ready = !rst && (state_q == IDLE);
  assign accept          = mem_if.in_valid && mem_if.in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    wr_en_d    = 1'b0;        // retire pulse lasts a single cycle
    wr_addr_d  = wr_addr_q;
    pc_d       = pc_q;
    ld_sign_d  = ld_sign_q;
    ld_lane_d  = ld_lane_q;
    ld_size_d  = ld_size_q;
    ld_wr_en_d = ld_wr_en_q;
    ld_addr_d  = ld_addr_q;
    ld_pc_d    = ld_pc_q;
`ifdef WB_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mem_if.mem_read_flag) begin
            ld_sign_d  = mem_if.mem_sign_ext_flag;
            ld_lane_d  = lane_eff;
            ld_size_d  = size_log;
            ld_wr_en_d = mem_if.reg_write_en_in;
            ld_addr_d  = mem_if.reg_write_addr_in;
            ld_pc_d    = mem_if.current_pc_addr_in;
            state_d    = WAIT_RAM;
`ifdef WB_MISALIGN_TRAP_EN
            // A rejected load overrides the above. It retires at once with
            // no register write and never waits for RAM data.
            if (load_illegal) begin
              state_d    = IDLE;
              result_d   = '0;
              wr_addr_d  = mem_if.reg_write_addr_in;
              pc_d       = mem_if.current_pc_addr_in;
              misalign_d = 1'b1;
            end
`endif
          end else begin
            result_d  = mem_if.mem_write_flag ? '0 : mem_if.result_in;
            wr_en_d   = mem_if.reg_write_en_in && !mem_if.mem_write_flag;
            wr_addr_d = mem_if.reg_write_addr_in;
            pc_d      = mem_if.current_pc_addr_in;
          end
        end
      end

      WAIT_RAM: begin
        if (ram_data_valid) begin
          result_d  = load_data;
          wr_en_d   = ld_wr_en_q;
          wr_addr_d = ld_addr_q;
          pc_d      = ld_pc_q;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All flops see the
  // values from before the edge, whatever their order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every flop is reset, including the load context. This block
      // holds no memory array, so a full reset costs nothing and keeps
      // simulation free of X values.
      state_q    <= IDLE;
      result_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      pc_q       <= '0;
      ld_sign_q  <= 1'b0;
      ld_lane_q  <= '0;
      ld_size_q  <= '0;
      ld_wr_en_q <= 1'b0;
      ld_addr_q  <= '0;
      ld_pc_q    <= '0;
`ifdef WB_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      pc_q       <= pc_d;
      ld_sign_q  <= ld_sign_d;
      ld_lane_q  <= ld_lane_d;
      ld_size_q  <= ld_size_d;
      ld_wr_en_q <= ld_wr_en_d;
      ld_addr_q  <= ld_addr_d;
      ld_pc_q    <= ld_pc_d;
`ifdef WB_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign result_out         = result_q;
  assign reg_write_en_out   = wr_en_q;
  assign reg_write_addr_out = wr_addr_q;
  assign debug_reg_write_en = wr_en_q;
  assign debug_pc_addr_out  = pc_q;
`ifdef WB_MISALIGN_TRAP_EN
  assign load_misalign      = misalign_q;
`else
  assign load_misalign      = 1'b0;
`endif

endmodule : wb_load_stage
